// File: rtl/operand_fifo_writer.sv
// Producer side of the multiplier operand FIFO: buffers {A,B} pairs and writes them to
// fifo_module under Left_Sig credit. Define OPWR_WORD_CNT_EN to add the Word_Count output.
module operand_fifo_writer #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned BUF_DEPTH  = 2
) (
  input  logic                CLK,
  input  logic                RSTn,
  input  logic                In_Valid,
  output logic                In_Ready,
  input  logic [DATA_W-1:0]   In_A,
  input  logic [DATA_W-1:0]   In_B,
  input  logic                Flush,
  input  logic [2:0]          Left_Sig,
  output logic                Write_Req,
  output logic [2*DATA_W-1:0] FIFO_Write_Data,
  output logic                Busy
`ifdef OPWR_WORD_CNT_EN
  ,
  output logic [15:0]         Word_Count
`endif
);

  localparam int unsigned CntW = $clog2(BUF_DEPTH + 1);
  localparam int unsigned PtrW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [CntW-1:0] CntFull = CntW'(BUF_DEPTH);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(BUF_DEPTH - 1);
  localparam logic [2:0]      LeftMax = 3'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StIssue, StStall} state_e;

  logic [2*DATA_W-1:0] buf_q [BUF_DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]     count_q, count_d;
  logic                write_req_q, write_req_d;
  logic [2*DATA_W-1:0] wdata_q, wdata_d;
  logic [2:0]          left_eff;
  logic                credit, accept, issue;
  state_e              state;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrLast) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    // A Left_Sig beyond the FIFO depth is meaningless; never trust more credit than slots.
    left_eff = (Left_Sig > LeftMax) ? LeftMax : Left_Sig;
    // The in-flight write is charged because Left_Sig has not yet seen it.
    credit   = left_eff > {2'b00, write_req_q};

    state = StIdle;
    if (count_q != '0) begin
      state = credit ? StIssue : StStall;
    end

    In_Ready = RSTn && (count_q != CntFull) && !Flush;
    accept   = In_Valid && In_Ready;
    issue    = (state == StIssue) && !Flush;

    wr_ptr_d    = accept ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d    = issue ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    write_req_d = issue;
    wdata_d     = issue ? buf_q[rd_ptr_q] : wdata_q;

    unique case ({accept, issue})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (Flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      write_req_q <= 1'b0;
      wdata_q     <= '0;
    end else begin
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      write_req_q <= write_req_d;
      wdata_q     <= wdata_d;
    end
  end

  // Storage needs no reset: count and pointers define which entries are live.
  always_ff @(posedge CLK) begin
    if (accept) begin
      buf_q[wr_ptr_q] <= {In_A, In_B};
    end
  end

  assign Write_Req       = write_req_q;
  assign FIFO_Write_Data = wdata_q;
  assign Busy            = (count_q != '0) || write_req_q;

`ifdef OPWR_WORD_CNT_EN
  logic [15:0] word_cnt_q;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      word_cnt_q <= '0;
    end else if (write_req_q) begin
      word_cnt_q <= word_cnt_q + 16'd1;
    end
  end

  assign Word_Count = word_cnt_q;
`endif

endmodule

// File: tb/tb_operand_fifo_writer.sv
// Randomized and directed bench for operand_fifo_writer against a queue-based model,
// with a FIFO stub that converts writes and reads into Left_Sig.
`timescale 1ns/1ps
module tb_operand_fifo_writer;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        In_Valid = 1'b0;
  logic        In_Ready;
  logic [7:0]  In_A = '0;
  logic [7:0]  In_B = '0;
  logic        Flush = 1'b0;
  logic [2:0]  Left_Sig = 3'd4;
  logic        Write_Req;
  logic [15:0] FIFO_Write_Data;
  logic        Busy;
`ifdef OPWR_WORD_CNT_EN
  logic [15:0] Word_Count;
`endif

  operand_fifo_writer dut (
    .CLK             (CLK),
    .RSTn            (RSTn),
    .In_Valid        (In_Valid),
    .In_Ready        (In_Ready),
    .In_A            (In_A),
    .In_B            (In_B),
    .Flush           (Flush),
    .Left_Sig        (Left_Sig),
    .Write_Req       (Write_Req),
    .FIFO_Write_Data (FIFO_Write_Data),
    .Busy            (Busy)
`ifdef OPWR_WORD_CNT_EN
    ,
    .Word_Count      (Word_Count)
`endif
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model: pending pairs, expected write strobe/data, word count.
  logic [15:0] q[$];
  logic        exp_wr = 1'b0;
  logic [15:0] exp_data = '0;
  logic [15:0] exp_wc = '0;
  logic        last_acc;

  // FIFO stub state.
  int          occ = 0;
  int          n_writes = 0;
  logic [15:0] last_written = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check_eq("write_req", Write_Req, exp_wr);
    check_eq("write_data", FIFO_Write_Data, exp_data);
    check_eq("busy", Busy, (q.size() != 0) || exp_wr);
`ifdef OPWR_WORD_CNT_EN
    check_eq("word_count", Word_Count, exp_wc);
`endif
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b,
                      input logic f, input logic rd);
    logic [2:0]  cur_left;
    logic        cur_wr;
    logic [15:0] cur_data;
    logic        issue;
    In_Valid = v;
    In_A     = a;
    In_B     = b;
    Flush    = f;
    #1;
    check_eq("in_ready", In_Ready, (q.size() < 2) && !f);
    cur_left = Left_Sig;
    cur_wr   = Write_Req;
    cur_data = FIFO_Write_Data;
    @(posedge CLK);
    issue    = !f && (q.size() != 0) && (int'(cur_left) > (exp_wr ? 1 : 0));
    last_acc = v && (q.size() < 2) && !f;
    if (exp_wr) exp_wc++;
    exp_wr = issue;
    if (issue) exp_data = q.pop_front();
    if (f) q.delete();
    else if (last_acc) q.push_back({a, b});
    @(negedge CLK);
    if (cur_wr) begin
      check_eq("write_with_credit", (cur_left != 0) && (occ < 4), 1);
      n_writes++;
      last_written = cur_data;
      occ++;
    end
    if (rd && occ > 0) occ--;
    Left_Sig = (occ >= 4) ? 3'd0 : 3'(4 - occ);
    check_outputs();
  endtask

  task automatic do_reset();
    In_Valid = 1'b0;
    Flush    = 1'b0;
    RSTn     = 1'b0;
    #1;
    check_eq("rst_write_req", Write_Req, 0);
    check_eq("rst_busy", Busy, 0);
    check_eq("rst_in_ready", In_Ready, 0);
    check_eq("rst_data", FIFO_Write_Data, 0);
`ifdef OPWR_WORD_CNT_EN
    check_eq("rst_word_count", Word_Count, 0);
`endif
    q.delete();
    exp_wr   = 1'b0;
    exp_data = '0;
    exp_wc   = '0;
    occ      = 0;
    Left_Sig = 3'd4;
    @(negedge CLK);
    RSTn = 1'b1;
  endtask

  initial begin
    int base;
    int sent;

    // Reset then idle.
    do_reset();
    #1;
    check_eq("idle_in_ready", In_Ready, 1);
    check_outputs();

    // Single pair with an empty FIFO.
    step(1'b1, 8'h12, 8'h34, 1'b0, 1'b0);
    step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    check_eq("single_req", Write_Req, 1);
    check_eq("single_data", FIFO_Write_Data, 16'h1234);
    step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    check_eq("single_busy_drop", Busy, 0);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);

    // Six pairs into a FIFO that is never read.
    base = n_writes;
    sent = 0;
    for (int c = 0; c < 20; c++) begin
      step(sent < 6, 8'(8'h40 + sent), 8'(8'h60 + sent), 1'b0, 1'b0);
      if (last_acc) sent++;
    end
    check_eq("stream_sent", sent, 6);
    check_eq("stream_writes", n_writes - base, 4);
    check_eq("stream_full_ready", In_Ready, 0);
    check_eq("stream_busy", Busy, 1);

    // One word read: exactly the fifth pair goes out.
    step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    for (int c = 0; c < 5; c++) step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    check_eq("drain1_writes", n_writes - base, 5);
    check_eq("drain1_order", last_written, 16'h4464);

    // Refill to two entries, then flush while stalled.
    step(1'b1, 8'h77, 8'h88, 1'b0, 1'b0);
    check_eq("preflush_ready", In_Ready, 0);
    step(1'b1, 8'h99, 8'h99, 1'b1, 1'b0);
    check_eq("flush_busy", Busy, 0);
    base = n_writes;
    for (int c = 0; c < 6; c++) step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    check_eq("flush_no_writes", n_writes - base, 0);
    step(1'b1, 8'hAB, 8'hCD, 1'b0, 1'b0);
    step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    check_eq("post_flush_data", last_written, 16'hABCD);

    // Reset while a write is on the bus.
    step(1'b1, 8'h55, 8'h66, 1'b0, 1'b1);
    step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    check_eq("pre_reset_req", Write_Req, 1);
    do_reset();

    // Randomized traffic with a slow reader and occasional flushes.
    for (int c = 0; c < 600; c++) begin
      step(($urandom % 4) != 0, 8'($urandom), 8'($urandom),
           ($urandom % 20) == 0, ($urandom % 3) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
